// File: rtl/control_fsm.sv
// Multicycle control sequencer: FETCH -> DECODE -> EXEC -> WB/BRANCH, with halt,
// illegal-opcode and retired-instruction status.
module control_fsm #(
    parameter int unsigned CNT_W   = 16,
    parameter logic [5:0]  HALT_OP = 6'b111111
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic [5:0]       opcode,
    input  logic             zf,
    output logic             pc_en,
    output logic             br,
    output logic             regdst,
    output logic             enable,
    output logic             alusrc,
    output logic [2:0]       aluop,
    output logic [2:0]       state,
    output logic             halted,
    output logic             illegal,
    output logic [CNT_W-1:0] retired
);

    typedef enum logic [2:0] {
        StFetch  = 3'd0,
        StDecode = 3'd1,
        StExec   = 3'd2,
        StWb     = 3'd3,
        StBranch = 3'd4,
        StHalt   = 3'd5
    } state_e;

    localparam logic [5:0] OpRtype = 6'b000000;
    localparam logic [5:0] OpAddi  = 6'b001000;
    localparam logic [5:0] OpAndi  = 6'b001100;
    localparam logic [5:0] OpOri   = 6'b001101;
    localparam logic [5:0] OpSlti  = 6'b001010;
    localparam logic [5:0] OpBeq   = 6'b000100;

    localparam logic [CNT_W-1:0] CntOne = {{(CNT_W-1){1'b0}}, 1'b1};

    state_e           state_q, state_d;
    logic [5:0]       ir_op_q;
    logic             halted_q, illegal_q;
    logic [CNT_W-1:0] retired_q;
    // Holds FETCH for one edge after reset release so sequencing restarts cleanly.
    logic             started_q;

    logic       cls_legal, cls_beq, cls_regdst, cls_alusrc, is_halt;
    logic [2:0] cls_aluop;
    logic       unused_zf;

    assign unused_zf = zf;
    assign is_halt   = (ir_op_q == HALT_OP);

    always_comb begin
        cls_legal  = 1'b1;
        cls_beq    = 1'b0;
        cls_aluop  = 3'b000;
        cls_regdst = 1'b0;
        cls_alusrc = 1'b0;
        case (ir_op_q)
            OpRtype: begin
                cls_aluop  = 3'b010;
                cls_regdst = 1'b1;
            end
            OpAddi: cls_alusrc = 1'b1;
            OpAndi: begin
                cls_aluop  = 3'b011;
                cls_alusrc = 1'b1;
            end
            OpOri: begin
                cls_aluop  = 3'b100;
                cls_alusrc = 1'b1;
            end
            OpSlti: begin
                cls_aluop  = 3'b101;
                cls_alusrc = 1'b1;
            end
            OpBeq: begin
                cls_aluop = 3'b001;
                cls_beq   = 1'b1;
            end
            default: cls_legal = 1'b0;
        endcase
    end

    always_comb begin
        state_d = state_q;
        pc_en   = 1'b0;
        br      = 1'b0;
        enable  = 1'b0;
        aluop   = 3'b000;
        regdst  = 1'b0;
        alusrc  = 1'b0;
        case (state_q)
            StFetch: begin
                if (started_q) state_d = StDecode;
            end
            StDecode: begin
                aluop  = cls_aluop;
                regdst = cls_regdst;
                alusrc = cls_alusrc;
                if (cls_legal) begin
                    state_d = StExec;
                end else if (is_halt) begin
                    state_d = StHalt;
                end else begin
                    pc_en   = 1'b1;
                    state_d = StFetch;
                end
            end
            StExec: begin
                aluop   = cls_aluop;
                regdst  = cls_regdst;
                alusrc  = cls_alusrc;
                state_d = cls_beq ? StBranch : StWb;
            end
            StWb: begin
                aluop   = cls_aluop;
                regdst  = cls_regdst;
                alusrc  = cls_alusrc;
                enable  = 1'b1;
                pc_en   = 1'b1;
                state_d = StFetch;
            end
            StBranch: begin
                aluop   = cls_aluop;
                regdst  = cls_regdst;
                alusrc  = cls_alusrc;
                br      = 1'b1;
                pc_en   = 1'b1;
                state_d = StFetch;
            end
            StHalt:  state_d = StHalt;
            default: state_d = StFetch;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q   <= StFetch;
            ir_op_q   <= 6'd0;
            halted_q  <= 1'b0;
            illegal_q <= 1'b0;
            retired_q <= '0;
            started_q <= 1'b0;
        end else begin
            started_q <= 1'b1;
            state_q   <= state_d;
            if (state_q == StFetch && started_q) ir_op_q <= opcode;
            if (state_q == StDecode && !cls_legal) begin
                if (is_halt) halted_q <= 1'b1;
                else illegal_q <= 1'b1;
            end
            if ((state_q == StWb || state_q == StBranch) && retired_q != '1) begin
                retired_q <= retired_q + CntOne;
            end
        end
    end

    assign state   = state_q;
    assign halted  = halted_q;
    assign illegal = illegal_q;
    assign retired = retired_q;

endmodule

// File: tb/tb_control_fsm.sv
// Bench for control_fsm: directed scenarios plus a random instruction stream
// checked cycle-by-cycle against an instruction-level expansion model.
module tb_control_fsm;

    localparam int unsigned CW = 4;

    logic          clk = 1'b0;
    logic          rst_n = 1'b0;
    logic [5:0]    opcode = 6'd0;
    logic          zf = 1'b0;
    logic          pc_en, br, regdst, enable, alusrc, halted, illegal;
    logic [2:0]    aluop, state;
    logic [CW-1:0] retired;

    int tests_run = 0;
    int fails = 0;

    control_fsm #(.CNT_W(CW), .HALT_OP(6'b111111)) dut (
        .clk(clk), .rst_n(rst_n), .opcode(opcode), .zf(zf),
        .pc_en(pc_en), .br(br), .regdst(regdst), .enable(enable), .alusrc(alusrc),
        .aluop(aluop), .state(state), .halted(halted), .illegal(illegal), .retired(retired)
    );

    always #5 clk = ~clk;

    // Expected cycle record; out = {state,pc_en,br,enable,regdst,alusrc,aluop,halted,illegal,retired}
    typedef struct packed {
        logic [16:0] out;
        logic        fetch;
        logic [5:0]  drv;
    } cyc_t;

    cyc_t exp_q[$];
    int   m_retired;
    logic m_illegal, m_halted;

    // {legal, is_beq, aluop[2:0], regdst, alusrc} from the opcode table
    function automatic logic [6:0] spec_cls(input logic [5:0] op);
        case (op)
            6'b000000: return 7'b1_0_010_1_0;
            6'b001000: return 7'b1_0_000_0_1;
            6'b001100: return 7'b1_0_011_0_1;
            6'b001101: return 7'b1_0_100_0_1;
            6'b001010: return 7'b1_0_101_0_1;
            6'b000100: return 7'b1_1_001_0_0;
            default:   return 7'b0;
        endcase
    endfunction

    function automatic void push(input logic [2:0] st, input logic pc, input logic b,
                                 input logic en, input logic [4:0] ctl, input logic f,
                                 input logic [5:0] d);
        cyc_t r;
        r.out   = {st, pc, b, en, ctl[1], ctl[0], ctl[4:2], m_halted, m_illegal,
                   4'(m_retired)};
        r.fetch = f;
        r.drv   = d;
        exp_q.push_back(r);
    endfunction

    function automatic void expand(input logic [5:0] op, input int halt_cycles);
        logic [6:0] c;
        c = spec_cls(op);
        push(3'd0, 1'b0, 1'b0, 1'b0, 5'd0, 1'b1, op);
        if (op == 6'b111111) begin
            push(3'd1, 1'b0, 1'b0, 1'b0, 5'd0, 1'b0, 6'd0);
            m_halted = 1'b1;
            for (int i = 0; i < halt_cycles; i++) push(3'd5, 1'b0, 1'b0, 1'b0, 5'd0, 1'b0, 6'd0);
        end else if (!c[6]) begin
            push(3'd1, 1'b1, 1'b0, 1'b0, 5'd0, 1'b0, 6'd0);
            m_illegal = 1'b1;
        end else begin
            push(3'd1, 1'b0, 1'b0, 1'b0, c[4:0], 1'b0, 6'd0);
            push(3'd2, 1'b0, 1'b0, 1'b0, c[4:0], 1'b0, 6'd0);
            if (c[5]) push(3'd4, 1'b1, 1'b1, 1'b0, c[4:0], 1'b0, 6'd0);
            else push(3'd3, 1'b1, 1'b0, 1'b1, c[4:0], 1'b0, 6'd0);
            m_retired = (m_retired >= 15) ? 15 : m_retired + 1;
        end
    endfunction

    // Leaves the bench at the falling edge of the first FETCH cycle that will latch opcode.
    task automatic do_reset();
        @(negedge clk);
        rst_n  = 1'b0;
        opcode = 6'd0;
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);
        m_retired = 0;
        m_illegal = 1'b0;
        m_halted  = 1'b0;
        exp_q.delete();
    endtask

    task automatic test_reset();
        do_reset();
        tests_run++;
        if ({state, halted, illegal, retired, pc_en, enable, br, aluop, regdst, alusrc} !== '0) begin
            fails++;
            $display("FAIL reset_values: got state=%0d h=%b i=%b ret=%0d pc=%b en=%b br=%b alu=%b, want all 0",
                     state, halted, illegal, retired, pc_en, enable, br, aluop);
        end
        opcode = 6'b001000;
        repeat (4) @(negedge clk);
        tests_run++;
        if (retired !== 4'd1) begin
            fails++;
            $display("FAIL reset_pre_retire: got %0d want 1", retired);
        end
        opcode = 6'b001000;
        repeat (2) @(negedge clk);
        tests_run++;
        if (state !== 3'd2 || alusrc !== 1'b1) begin
            fails++;
            $display("FAIL reset_in_exec: got state=%0d alusrc=%b want 2/1", state, alusrc);
        end
        #1 rst_n = 1'b0;
        #1;
        tests_run++;
        if ({state, enable, pc_en, retired, alusrc} !== '0) begin
            fails++;
            $display("FAIL reset_async: got state=%0d en=%b pc=%b ret=%0d alusrc=%b want 0",
                     state, enable, pc_en, retired, alusrc);
        end
        @(negedge clk);
        rst_n = 1'b1;
        @(posedge clk);
        #1;
        tests_run++;
        if (state !== 3'd0) begin
            fails++;
            $display("FAIL reset_first_edge: got state=%0d want 0", state);
        end
        @(posedge clk);
        #1;
        tests_run++;
        if (state !== 3'd1) begin
            fails++;
            $display("FAIL reset_decode_after_two: got state=%0d want 1", state);
        end
    endtask

    task automatic test_rtype_addi();
        logic [5:0] ops[2];
        logic [4:0] ctl[2];
        ops[0] = 6'b000000; ctl[0] = 5'b010_1_0;
        ops[1] = 6'b001000; ctl[1] = 5'b000_0_1;
        do_reset();
        for (int i = 0; i < 2; i++) begin
            opcode = ops[i];
            for (int c = 0; c < 4; c++) begin
                if (c > 0) begin
                    tests_run++;
                    if ({aluop, regdst, alusrc} !== ctl[i]) begin
                        fails++;
                        $display("FAIL rtype_addi_ctl[%0d,%0d]: got %b want %b", i, c,
                                 {aluop, regdst, alusrc}, ctl[i]);
                    end
                end
                tests_run++;
                if ({enable, pc_en} !== ((c == 3) ? 2'b11 : 2'b00)) begin
                    fails++;
                    $display("FAIL rtype_addi_pulse[%0d,%0d]: got en/pc=%b%b", i, c, enable, pc_en);
                end
                @(negedge clk);
                opcode = 6'($urandom);
            end
        end
        tests_run++;
        if (retired !== 4'd2) begin
            fails++;
            $display("FAIL rtype_addi_retired: got %0d want 2", retired);
        end
    endtask

    task automatic test_beq();
        logic [2:0] st_exp[4];
        st_exp[0] = 3'd0; st_exp[1] = 3'd1; st_exp[2] = 3'd2; st_exp[3] = 3'd4;
        for (int z = 0; z < 2; z++) begin
            do_reset();
            zf     = z[0];
            opcode = 6'b000100;
            for (int c = 0; c < 4; c++) begin
                tests_run++;
                if (state !== st_exp[c] || {br, pc_en, enable} !== ((c == 3) ? 3'b110 : 3'b000)
                    || (c > 0 && aluop !== 3'b001)) begin
                    fails++;
                    $display("FAIL beq[zf=%0d,c=%0d]: got st=%0d br/pc/en=%b%b%b alu=%b want st=%0d",
                             z, c, state, br, pc_en, enable, aluop, st_exp[c]);
                end
                @(negedge clk);
                opcode = 6'($urandom);
            end
            tests_run++;
            if (retired !== 4'd1) begin
                fails++;
                $display("FAIL beq_retired[zf=%0d]: got %0d want 1", z, retired);
            end
        end
        zf = 1'b0;
    endtask

    task automatic test_illegal();
        do_reset();
        opcode = 6'b010101;
        @(negedge clk);
        tests_run++;
        if (state !== 3'd1 || pc_en !== 1'b1 || enable !== 1'b0) begin
            fails++;
            $display("FAIL illegal_decode: got st=%0d pc=%b en=%b want 1/1/0", state, pc_en, enable);
        end
        @(negedge clk);
        tests_run++;
        if (state !== 3'd0 || illegal !== 1'b1 || retired !== 4'd0) begin
            fails++;
            $display("FAIL illegal_after: got st=%0d ill=%b ret=%0d want 0/1/0", state, illegal, retired);
        end
        opcode = 6'b001101;
        for (int c = 0; c < 4; c++) begin
            if (c > 0) begin
                tests_run++;
                if (aluop !== 3'b100 || alusrc !== 1'b1 || enable !== (c == 3)) begin
                    fails++;
                    $display("FAIL illegal_ori[%0d]: got alu=%b src=%b en=%b", c, aluop, alusrc, enable);
                end
            end
            @(negedge clk);
            opcode = 6'($urandom);
        end
        tests_run++;
        if (retired !== 4'd1 || illegal !== 1'b1) begin
            fails++;
            $display("FAIL illegal_ori_end: got ret=%0d ill=%b want 1/1", retired, illegal);
        end
    endtask

    task automatic test_halt();
        do_reset();
        opcode = 6'b111111;
        repeat (2) @(negedge clk);
        tests_run++;
        if (state !== 3'd5 || halted !== 1'b1) begin
            fails++;
            $display("FAIL halt_enter: got st=%0d halted=%b want 5/1", state, halted);
        end
        for (int c = 0; c < 20; c++) begin
            opcode = 6'($urandom);
            @(negedge clk);
            tests_run++;
            if (state !== 3'd5 || {pc_en, enable, br, aluop, regdst, alusrc} !== '0) begin
                fails++;
                $display("FAIL halt_hold[%0d]: got st=%0d pc=%b en=%b br=%b alu=%b", c, state,
                         pc_en, enable, br, aluop);
            end
        end
        #1 rst_n = 1'b0;
        #1;
        tests_run++;
        if (halted !== 1'b0 || state !== 3'd0) begin
            fails++;
            $display("FAIL halt_clear: got halted=%b st=%0d want 0/0", halted, state);
        end
        @(negedge clk);
        rst_n = 1'b1;
    endtask

    task automatic test_saturation();
        int want;
        do_reset();
        for (int i = 0; i < 17; i++) begin
            opcode = 6'b001000;
            repeat (4) @(negedge clk);
            want = (i + 1 > 15) ? 15 : i + 1;
            tests_run++;
            if (retired !== 4'(want)) begin
                fails++;
                $display("FAIL saturation[%0d]: got %0d want %0d", i, retired, want);
            end
        end
    endtask

    task automatic test_random();
        logic [5:0] pool[6];
        logic [5:0] op;
        logic [16:0] act;
        cyc_t r;
        int n;
        pool[0] = 6'b000000; pool[1] = 6'b001000; pool[2] = 6'b001100;
        pool[3] = 6'b001101; pool[4] = 6'b001010; pool[5] = 6'b000100;
        do_reset();
        for (int i = 0; i < 30; i++) begin
            if ($urandom_range(0, 4) == 0) begin
                do op = 6'($urandom); while (spec_cls(op) != 7'b0 || op == 6'b111111);
            end else begin
                op = pool[$urandom_range(0, 5)];
            end
            expand(op, 0);
        end
        expand(6'b111111, 5);
        n = 0;
        while (exp_q.size() > 0) begin
            r   = exp_q.pop_front();
            act = {state, pc_en, br, enable, regdst, alusrc, aluop, halted, illegal, retired};
            tests_run++;
            if (act !== r.out) begin
                fails++;
                $display("FAIL random_cycle[%0d]: got %b want %b", n, act, r.out);
            end
            opcode = r.fetch ? r.drv : 6'($urandom);
            zf     = 1'($urandom);
            n++;
            @(negedge clk);
        end
    endtask

    initial begin
        test_reset();
        test_rtype_addi();
        test_beq();
        test_illegal();
        test_halt();
        test_saturation();
        test_random();
        $display("[TB] %0d tests run, %0d failed", tests_run, fails);
        $finish;
    end

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

endmodule

// File: doc/control_fsm.md
Name: control_fsm

Overview:
Multicycle control unit that sits directly upstream of the single-cycle datapath and drives its control inputs (br, regdst, enable, alusrc, aluop). It latches the opcode field of the fetched instruction and sequences each instruction through FETCH, DECODE and EXEC, then WB or BRANCH. It provides a PC-advance strobe so the PC updates once per retired instruction. It also tracks halt, illegal-opcode and retired-instruction status.

Parameters:
CNT_W, 16, width of retired-instruction counter (saturating)
HALT_OP, 6'b111111, opcode that stops the sequencer

Ports:
clk  input  1  system clock, rising edge
rst_n  input  1  asynchronous active-low reset
opcode  input  6  instruction bits [31:26] from instruction memory
zf  input  1  ALU zero flag (status only, not used for branching here)
pc_en  output  1  PC advance strobe, one cycle per instruction
br  output  1  branch request to datapath (ANDed with zf downstream)
regdst  output  1  1 = write rd (instr[15:11]), 0 = write rt (instr[20:16])
enable  output  1  register-file write enable
alusrc  output  1  1 = sign-extended immediate, 0 = rt register
aluop  output  3  ALU control class
state  output  3  current state encoding, for debug
halted  output  1  sticky, set on HALT_OP
illegal  output  1  sticky, set on unknown opcode
retired  output  CNT_W  count of completed legal instructions

Behaviour:
- Single clock domain. Reset is asynchronous and active-low (rst_n). All registers clear immediately on rst_n=0 and hold while it is low.
- Reset values: state=FETCH, ir_op=0, halted=0, illegal=0, retired=0. All control outputs are 0 while in reset.
- State encoding: FETCH=0, DECODE=1, EXEC=2, WB=3, BRANCH=4, HALT=5. Values 6 and 7 are unused and go to FETCH on the next edge.
- FETCH: latch opcode into ir_op; next state DECODE. All controls are 0.
- DECODE: classify ir_op.
  - Legal opcode: next state EXEC.
  - ir_op == HALT_OP: next state HALT; set halted.
  - Any other opcode: set illegal, assert pc_en for this cycle, next state FETCH. Not counted in retired.
- Legal opcodes, with class and aluop/regdst/alusrc:
  - 000000 R-type: aluop=010, regdst=1, alusrc=0
  - 001000 addi: aluop=000, regdst=0, alusrc=1
  - 001100 andi: aluop=011, regdst=0, alusrc=1
  - 001101 ori: aluop=100, regdst=0, alusrc=1
  - 001010 slti: aluop=101, regdst=0, alusrc=1
  - 000100 beq: aluop=001, regdst=0, alusrc=0
- Outputs are combinational from (state, ir_op) and are glitch-free relative to clk.
- aluop, regdst and alusrc are driven from DECODE through WB/BRANCH for the latched class. They are 0 in FETCH and HALT.
- EXEC: ALU operands settle. Next state is BRANCH for beq, otherwise WB.
- WB: enable=1 and pc_en=1 for exactly one cycle; retired increments; next state FETCH.
- BRANCH: br=1 and pc_en=1 for one cycle; enable=0; retired increments; next state FETCH.
- HALT: terminal. All controls are 0, pc_en=0, and the state holds until rst_n is asserted.
- Latency: 4 cycles per legal instruction, 2 for illegal, 2 to reach HALT.
- retired saturates at 2^CNT_W-1 and never wraps.
- halted and illegal are sticky until reset.
- Reset mid-instruction: the in-flight instruction is abandoned with no enable or pc_en pulse. Sequencing restarts at FETCH on the first clk edge after rst_n deasserts.
- Invariants: enable and br are never both 1; pc_en is never high in FETCH, EXEC or HALT.

Test Plan:
- Reset: rst_n=0 mid-EXEC of addi -> state=0, enable=0, pc_en=0, retired=0 immediately (asynchronously). After release, DECODE is reached two edges later.
- R-type then addi: opcode=000000 then 001000 -> aluop 010/regdst=1/alusrc=0, then aluop 000/regdst=0/alusrc=1. enable and pc_en each pulse once per instruction at cycles 4 and 8; retired=2.
- beq: opcode=000100 -> br=1, pc_en=1, enable=0 in cycle 4 only, aluop=001; retired=1. The pulse is identical for zf=0 and zf=1.
- Illegal: opcode=010101 -> illegal=1, pc_en in cycle 2, back to FETCH in cycle 3, retired unchanged. A following ori (001101) executes normally with aluop=100.
- Halt: opcode=111111 -> halted=1, state=5. No pc_en or enable for 20 cycles regardless of opcode input; rst_n pulse clears halted.
- Saturation with CNT_W=4: 17 consecutive addi -> retired stops at 15 and stays there.
